// File: rtl/scirc_ser_pkg.sv
// -----------------------------------------------------------------------------
// scirc_ser_pkg
// Shared definitions for the serial feed sequencer of the 4-bit load/shift
// register stage: FSM state encoding and the header nibble width.
// -----------------------------------------------------------------------------
package scirc_ser_pkg;

   // Width of the parallel header nibble loaded into the register.
   localparam int HDR_W = 4;

   // Explicit 2-bit encodings so the state register layout is stable.
   localparam logic [1:0] ENC_IDLE  = 2'b00;
   localparam logic [1:0] ENC_LOAD  = 2'b01;
   localparam logic [1:0] ENC_SHIFT = 2'b10;
   localparam logic [1:0] ENC_DONE  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = ENC_IDLE,
      LOAD  = ENC_LOAD,
      SHIFT = ENC_SHIFT,
      DONE  = ENC_DONE
   } state_t;

endpackage

// File: rtl/scirc_ser_cnt.sv
// -----------------------------------------------------------------------------
// scirc_ser_cnt
// Loadable down-counter with enable and zero flag. Counts the shift cycles
// still to be issued in a frame (payload bits, plus the parity bit when that
// option is built in).
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous reset, active-low; clears the count
//   load_i      load load_val_i (has priority over en_i)
//   load_val_i  value to load
//   en_i        decrement by one (ignored once the count is zero)
//   zero_o      count equals zero
// -----------------------------------------------------------------------------
module scirc_ser_cnt
   import scirc_ser_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && !zero_o) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scirc_ser_feed.sv
// -----------------------------------------------------------------------------
// scirc_ser_feed
// Upstream sequencer for the 4-bit load/shift register stage. Accepts a header
// nibble and a WIDTH-bit payload over valid/ready, then drives a one-cycle
// parallel load of the header followed by the payload shifted out MSB-first,
// and finally a one-cycle done pulse. All outputs are registered.
//
// Optional build macro: SCIRC_SER_PARITY_EN
//   defined   : one extra shift cycle carries the XOR of the header and all
//               payload bits (even parity) after the last payload bit.
//   undefined : exactly WIDTH shift cycles, no parity logic.
//
// Parameters:
//   WIDTH      payload bits per frame, 1..32
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous reset, active-low; aborts any frame in progress
//   valid_i    upstream frame valid
//   ready_o    block can accept a frame (IDLE)
//   hdr_i4     header nibble, captured on handshake
//   data_i     payload word, captured on handshake
//   hold_i     stall request, honoured only while shifting
//   ld_o       parallel-load strobe to the register
//   I_o4       parallel nibble (captured header, held until next load)
//   shift_o    shift strobe to the register
//   bstream_o  serial bit to the register (holds its last value when idle)
//   busy_o     frame in progress (LOAD, SHIFT, DONE)
//   done_o     one-cycle frame-complete pulse
// -----------------------------------------------------------------------------
module scirc_ser_feed
   import scirc_ser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [HDR_W-1:0] hdr_i4,
   input  logic [WIDTH-1:0] data_i,
   input  logic             hold_i,
   output logic             ld_o,
   output logic [HDR_W-1:0] I_o4,
   output logic             shift_o,
   output logic             bstream_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int CNT_W = $clog2(WIDTH + 2);

`ifdef SCIRC_SER_PARITY_EN
   localparam int N_SHIFT = WIDTH + 1;
`else
   localparam int N_SHIFT = WIDTH;
`endif

   state_t             state_q, state_d;
   logic [N_SHIFT-1:0] pay_q;
   logic [N_SHIFT-1:0] pay_cap;
   logic [HDR_W-1:0]   hdr_q;
   logic               capture;
   logic               do_shift;
   logic               cnt_zero;

   // Shift word as captured: payload, optionally followed by the parity bit
   // so the whole frame leaves through the same MSB tap.
`ifdef SCIRC_SER_PARITY_EN
   assign pay_cap = {data_i, ^{hdr_i4, data_i}};
`else
   assign pay_cap = data_i;
`endif

   // Remaining shifts. Loaded on the handshake so the first shift can be
   // issued on the edge that leaves LOAD.
   scirc_ser_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (capture),
      .load_val_i (CNT_W'(N_SHIFT)),
      .en_i       (do_shift),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // state_q names the phase currently visible on the outputs; state_d and
   // do_shift decide what the next cycle shows. Because the outputs are
   // registered, a shift issued here appears on shift_o in the next cycle.
   // NOTE: every combinational output gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      do_shift = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_i && ready_o) begin
               capture = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            do_shift = 1'b1;
            state_d  = SHIFT;
         end
         SHIFT: begin
            // All shifts issued: the last one is on the outputs now.
            if (cnt_zero) begin
               state_d = DONE;
            end else if (!hold_i) begin
               do_shift = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered outputs and datapath. ld_o only follows IDLE and do_shift only
   // occurs in LOAD/SHIFT, so the two strobes can never coincide.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ready_o   <= 1'b1;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         ld_o      <= 1'b0;
         shift_o   <= 1'b0;
         bstream_o <= 1'b0;
         hdr_q     <= '0;
         pay_q     <= '0;
      end else begin
         ready_o <= (state_d == IDLE);
         busy_o  <= (state_d != IDLE);
         done_o  <= (state_d == DONE);
         ld_o    <= (state_d == LOAD);
         shift_o <= do_shift;
         if (capture) begin
            hdr_q <= hdr_i4;
            pay_q <= pay_cap;
         end else if (do_shift) begin
            bstream_o <= pay_q[N_SHIFT-1];
            pay_q     <= pay_q << 1;
         end
      end
   end

   assign I_o4 = hdr_q;

endmodule

// File: tb/tb_scirc_ser_feed.sv
// -----------------------------------------------------------------------------
// tb_scirc_ser_feed
// Scoreboard bench for scirc_ser_feed with three instances (WIDTH 8, 1, 32).
// Stimulus pushes the expected frame on each handshake; a negedge monitor pops
// it on ld_o, collects the serial bits and a model of the downstream 4-bit
// register, and compares everything on done_o.
// -----------------------------------------------------------------------------
module tb_scirc_ser_feed;

`ifdef SCIRC_SER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   typedef struct {
      int          dut;
      logic [3:0]  hdr;
      logic [63:0] seq;   // k-th serial bit is seq[nb-1-k]
      int          nb;
      logic [3:0]  r4;    // downstream register after the frame
      int          hs;    // cycle in which the handshake was presented
      int          lat;   // cycles from handshake to done_o
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [2:0]  vld, hold_w;
   logic [3:0]  hdr_a [3];
   logic [7:0]  d8;
   logic [0:0]  d1;
   logic [31:0] d32;
   logic [2:0]  rdy_w, ld_w, sh_w, bs_w, busy_w, done_w;
   logic [3:0]  io_w [3];

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   last_hs [3];
   exp_t sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   scirc_ser_feed #(.WIDTH(8)) u_w8 (
      .clk_i(clk), .rst_i(rst_i), .valid_i(vld[0]), .ready_o(rdy_w[0]),
      .hdr_i4(hdr_a[0]), .data_i(d8), .hold_i(hold_w[0]), .ld_o(ld_w[0]),
      .I_o4(io_w[0]), .shift_o(sh_w[0]), .bstream_o(bs_w[0]),
      .busy_o(busy_w[0]), .done_o(done_w[0]));

   scirc_ser_feed #(.WIDTH(1)) u_w1 (
      .clk_i(clk), .rst_i(rst_i), .valid_i(vld[1]), .ready_o(rdy_w[1]),
      .hdr_i4(hdr_a[1]), .data_i(d1), .hold_i(hold_w[1]), .ld_o(ld_w[1]),
      .I_o4(io_w[1]), .shift_o(sh_w[1]), .bstream_o(bs_w[1]),
      .busy_o(busy_w[1]), .done_o(done_w[1]));

   scirc_ser_feed #(.WIDTH(32)) u_w32 (
      .clk_i(clk), .rst_i(rst_i), .valid_i(vld[2]), .ready_o(rdy_w[2]),
      .hdr_i4(hdr_a[2]), .data_i(d32), .hold_i(hold_w[2]), .ld_o(ld_w[2]),
      .I_o4(io_w[2]), .shift_o(sh_w[2]), .bstream_o(bs_w[2]),
      .busy_o(busy_w[2]), .done_o(done_w[2]));

   function automatic int wid(input int d);
      case (d)
         0:       return 8;
         1:       return 1;
         default: return 32;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference frame: payload MSB-first, optional parity bit, and the
   // downstream register (loaded with the header, then shifted).
   task automatic model(input int w, input logic [3:0] h, input logic [31:0] dat,
                        output logic [63:0] seq, output int nb, output logic [3:0] r4);
      logic p;
      logic b;
      seq = '0;
      nb  = 0;
      p   = ^h;
      r4  = h;
      for (int k = w - 1; k >= 0; k--) begin
         b   = dat[k];
         p   = p ^ b;
         seq = {seq[62:0], b};
         r4  = {r4[2:0], b};
         nb++;
      end
      if (PAR != 0) begin
         seq = {seq[62:0], p};
         r4  = {r4[2:0], p};
         nb++;
      end
   endtask

   // Present a frame, wait (bounded) for the handshake, log the expectation.
   // Called right after a negedge; returns at the negedge showing LOAD.
   task automatic send(input int d, input logic [3:0] h, input logic [31:0] dat,
                       input logic [63:0] seq, input int nb, input logic [3:0] r4,
                       input int holds, input bit keep, input bit exact_gap);
      int   n;
      int   shifts;
      exp_t e;
      hdr_a[d] = h;
      case (d)
         0:       d8  = dat[7:0];
         1:       d1  = dat[0:0];
         default: d32 = dat;
      endcase
      vld[d] = 1'b1;
      n = 0;
      while (!rdy_w[d] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!rdy_w[d]) begin
         tests++;
         fails++;
         $display("FAIL handshake_timeout dut%0d: ready_o stayed 0, expected 1", d);
         vld[d] = 1'b0;
         return;
      end
      if (last_hs[d] >= 0) begin
         if (exact_gap)
            check("frame_gap_exact", 64'(cyc - last_hs[d]), 64'(wid(d) + PAR + 3));
         else
            check("frame_gap_min", 64'(cyc - last_hs[d] >= wid(d) + PAR + 3), 64'd1);
      end
      last_hs[d] = cyc;
      e.dut = d;
      e.hdr = h;
      e.seq = seq;
      e.nb  = nb;
      e.r4  = r4;
      e.hs  = cyc;
      e.lat = wid(d) + PAR + 2 + holds;
      sb.push_back(e);
      @(negedge clk);
      if (!keep) vld[d] = 1'b0;
      if (holds > 0) begin
         shifts = 0;
         n = 0;
         while (shifts < 2 && n < 100) begin
            @(negedge clk);
            if (sh_w[d]) shifts++;
            n++;
         end
         hold_w[d] = 1'b1;
         repeat (holds) @(negedge clk);
         hold_w[d] = 1'b0;
      end
   endtask

   // ---------------------------------------------------------------- monitor
   exp_t        cur   [3];
   bit          cur_v [3];
   logic [63:0] got   [3];
   int          nsh   [3];
   int          ovl   [3];
   logic [3:0]  r4m   [3];

   initial begin
      for (int d = 0; d < 3; d++) cur_v[d] = 1'b0;
   end

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         int idx;
         // A frame that loses busy_o before done_o was aborted by reset.
         if (cur_v[d] && !busy_w[d]) cur_v[d] = 1'b0;
         if (ld_w[d]) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
               if (sb[i].dut == d && idx < 0) idx = i;
            if (idx < 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_load dut%0d: ld_o=1 with no frame queued", d);
            end else begin
               cur[d]   = sb[idx];
               sb.delete(idx);
               cur_v[d] = 1'b1;
               got[d]   = '0;
               nsh[d]   = 0;
               ovl[d]   = 0;
               r4m[d]   = io_w[d];
               check("ld_header", 64'(io_w[d]), 64'(cur[d].hdr));
               check("ld_latency", 64'(cyc - cur[d].hs), 64'd1);
            end
         end else if (sh_w[d] && cur_v[d]) begin
            got[d] = {got[d][62:0], bs_w[d]};
            r4m[d] = {r4m[d][2:0], bs_w[d]};
            nsh[d]++;
         end
         if (ld_w[d] && sh_w[d]) ovl[d]++;
         if (done_w[d]) begin
            if (!cur_v[d]) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done dut%0d: done_o=1 with no frame active", d);
            end else begin
               check("shift_count",      64'(nsh[d]), 64'(cur[d].nb));
               check("bit_sequence",     got[d], cur[d].seq);
               check("done_latency",     64'(cyc - cur[d].hs), 64'(cur[d].lat));
               check("downstream_reg",   64'(r4m[d]), 64'(cur[d].r4));
               check("ld_shift_overlap", 64'(ovl[d]), 64'd0);
               cur_v[d] = 1'b0;
            end
         end
      end
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      logic [63:0] seq;
      int          nb;
      int          n;
      int          shifts;
      logic [3:0]  r4;
      logic [3:0]  h;
      logic [31:0] dat;

      rst_i  = 1'b0;
      vld    = '0;
      hold_w = '0;
      d8     = '0;
      d1     = '0;
      d32    = '0;
      for (int d = 0; d < 3; d++) begin
         hdr_a[d]   = '0;
         last_hs[d] = -1;
      end

      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++)
         check("reset_outputs",
               64'({rdy_w[d], busy_w[d], done_w[d], ld_w[d], sh_w[d], bs_w[d], io_w[d]}),
               64'(10'b10_0000_0000));
      rst_i = 1'b1;
      @(negedge clk);

      // Nominal frame hdr=5, data=B4.
`ifdef SCIRC_SER_PARITY_EN
      send(0, 4'h5, 32'hB4, 64'b1_0110_1000, 9, 4'h8, 0, 1'b0, 1'b0);
`else
      send(0, 4'h5, 32'hB4, 64'hB4, 8, 4'h4, 0, 1'b0, 1'b0);
`endif
      n = 0;
      while (!rdy_w[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("hdr_held_after_frame", 64'(io_w[0]), 64'h5);

      // Same frame with a 3-cycle hold after the second shift.
`ifdef SCIRC_SER_PARITY_EN
      send(0, 4'h5, 32'hB4, 64'b1_0110_1000, 9, 4'h8, 3, 1'b0, 1'b0);
`else
      send(0, 4'h5, 32'hB4, 64'hB4, 8, 4'h4, 3, 1'b0, 1'b0);
`endif

      // Backpressure: valid stays high, data switches to the next frame while
      // busy; the second frame is taken on the first ready cycle.
`ifdef SCIRC_SER_PARITY_EN
      send(0, 4'h6, 32'h5A, 64'b0_1011_0100, 9, 4'h4, 0, 1'b1, 1'b0);
      send(0, 4'h9, 32'h3C, 64'b0_0111_1000, 9, 4'h8, 0, 1'b0, 1'b1);
`else
      send(0, 4'h6, 32'h5A, 64'h5A, 8, 4'hA, 0, 1'b1, 1'b0);
      send(0, 4'h9, 32'h3C, 64'h3C, 8, 4'hC, 0, 1'b0, 1'b1);
`endif

      // Parity vectors (plain frames when parity is not built in).
`ifdef SCIRC_SER_PARITY_EN
      send(0, 4'h1, 32'h03, 64'b0_0000_0111, 9, 4'h7, 0, 1'b0, 1'b0);
      send(0, 4'h3, 32'h03, 64'b0_0000_0110, 9, 4'h6, 0, 1'b0, 1'b0);
`else
      send(0, 4'h1, 32'h03, 64'h03, 8, 4'h3, 0, 1'b0, 1'b0);
      send(0, 4'h3, 32'h03, 64'h03, 8, 4'h3, 0, 1'b0, 1'b0);
`endif

      // Reset on the third shift: frame discarded, no done_o afterwards.
      model(8, 4'hA, 32'hC3, seq, nb, r4);
      send(0, 4'hA, 32'hC3, seq, nb, r4, 0, 1'b0, 1'b0);
      shifts = 0;
      n = 0;
      while (shifts < 3 && n < 50) begin
         @(negedge clk);
         if (sh_w[0]) shifts++;
         n++;
      end
      check("shifts_before_reset", 64'(shifts), 64'd3);
      rst_i = 1'b0;
      @(negedge clk);
      check("reset_mid_shift",
            64'({rdy_w[0], busy_w[0], done_w[0], ld_w[0], sh_w[0], bs_w[0], io_w[0]}),
            64'(10'b10_0000_0000));
      rst_i = 1'b1;
      repeat (15) @(negedge clk);

      // Random frames on all three widths, overlapping across instances.
      for (int i = 0; i < 4; i++) begin
         for (int d = 0; d < 3; d++) begin
            h   = 4'($urandom_range(0, 15));
            dat = $urandom;
            model(wid(d), h, dat, seq, nb, r4);
            send(d, h, dat, seq, nb, r4, 0, 1'b0, 1'b0);
         end
      end

      n = 0;
      while ((sb.size() > 0 || cur_v[0] || cur_v[1] || cur_v[2]) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0 || cur_v[0] || cur_v[1] || cur_v[2]) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d frames still pending, expected 0", sb.size());
      end
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/scirc_ser_feed.md
Name: scirc_ser_feed

Overview:
Upstream sequencer for the 4-bit load/shift register stage. It accepts a header nibble and a WIDTH-bit payload word over a valid/ready handshake. It then drives the register's load strobe, parallel nibble, shift strobe and serial bit, MSB-first. A one-cycle done pulse marks frame completion, so downstream logic samples the register contents at a defined point.

Parameters:
WIDTH, 8, payload bits shifted per frame; legal range 1..32
CNT_W, $clog2(WIDTH+2), bit-counter width; derived, not overridden

Ports:
clk_i  input  1  sole clock, rising edge
rst_i  input  1  synchronous reset, active-low (one clock; reset is synchronous and active-low)
valid_i  input  1  upstream frame valid
ready_o  output  1  block can accept a frame
hdr_i4  input  4  header nibble, loaded in parallel
data_i  input  WIDTH  payload, shifted out MSB-first
hold_i  input  1  stall request during shifting
ld_o  output  1  parallel-load strobe to register
I_o4  output  4  parallel nibble to register
shift_o  output  1  shift strobe to register
bstream_o  output  1  serial bit to register
busy_o  output  1  frame in progress
done_o  output  1  one-cycle frame-complete pulse

Behaviour:
- Reset (rst_i=0 at a rising edge): state=IDLE; ready_o=1; ld_o=0; shift_o=0; bstream_o=0; I_o4=0; busy_o=0; done_o=0; payload/header capture registers and counter cleared. Reset overrides everything, including mid-frame; the partial frame is discarded and no done_o is issued.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: ready_o=1. A handshake occurs when valid_i&ready_o is high at an edge. On a handshake, capture hdr_i4 and data_i and go to LOAD. Without a handshake, stay in IDLE.
- LOAD (exactly 1 cycle): ld_o=1, I_o4=captured header, shift_o=0, ready_o=0, busy_o=1. Next state is SHIFT with counter=WIDTH.
- SHIFT: when hold_i=0, shift_o=1 and bstream_o=current payload MSB; the payload shifts left by 1 and the counter decrements. When hold_i=1, shift_o=0, bstream_o holds its last value, and the counter and payload freeze. When the counter reaches 0 after the last shift, go to DONE.
- SHIFT exits after exactly WIDTH cycles with hold_i=0; hold has no timeout.
- ld_o and shift_o are never high in the same cycle. This is a hard invariant, because the register gives shift priority.
- DONE (exactly 1 cycle): done_o=1, shift_o=0, busy_o=1, ready_o=0. Next state is IDLE.
- ready_o rises the cycle after DONE, so there are no back-to-back frames: minimum frame period is WIDTH+3 cycles.
- I_o4 holds the captured header until the next LOAD.
- valid_i while not ready: ignored; the upstream must hold valid_i and its data until ready_o.
- hold_i outside SHIFT: ignored.
- Latency: handshake edge → ld_o=1 next cycle → first shift_o the cycle after that → done_o at cycle WIDTH+2 after the handshake, with no holds.

Optional Feature:
Macro SCIRC_SER_PARITY_EN.
- Defined: SHIFT runs WIDTH+1 shift cycles. The final bit is even parity over the 4 header bits plus all WIDTH payload bits, i.e. the XOR of all of them. hold_i applies to the parity cycle too. done_o is delayed by one cycle accordingly.
- Undefined: exactly WIDTH shift cycles; no parity logic is synthesized.

Decomposition:
- Package scirc_ser_pkg: state enum (IDLE, LOAD, SHIFT, DONE), 2-bit state encoding constants, HDR_W=4 constant.
- One natural sub-module, scirc_ser_cnt: a loadable down-counter with enable (hold gating) and a zero flag. It is reused for the parity-extended count.

Test Plan:
- Reset mid-SHIFT: WIDTH=8, hdr=4'hA, data=8'hC3; rst_i=0 at 3rd shift → next cycle all outputs 0, ready_o=1; no done_o.
- Nominal frame: WIDTH=8, hdr=4'h5, data=8'hB4 → ld_o pulse with I_o4=5, then shift_o for 8 cycles with bstream 1,0,1,1,0,1,0,0. done_o at cycle 10 after handshake; downstream 4-bit register = 4'h4.
- Hold: same frame with hold_i=1 for 3 cycles after the 2nd shift → exactly 8 shift_o pulses, bit order unchanged, done_o delayed by 3 cycles.
- Backpressure: valid_i held high with data changing while busy → only the first frame is sent; the second is accepted on the first cycle ready_o=1.
- Invariant check over random frames, WIDTH=1 and WIDTH=32 included → ld_o&shift_o never both 1; period ≥ WIDTH+3.
- Parity (SCIRC_SER_PARITY_EN defined): hdr=4'h1, data=8'h03 → 9 shifts, last bit 1; hdr=4'h3, data=8'h03 → last bit 0.
